// File: rtl/sd_pkg.sv
// Shared definitions for the SD sector loader and the sd_controller it drives.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package sd_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_READY,
        S_ISSUE,
        S_RECV,
        S_WAIT_END,
        S_DONE
    } state_t;

    localparam int SECTOR_BYTES = 512;
    localparam int SD_ADDR_W    = 32;

    // sd_controller handshake: ready is high only in its IDLE state, and a
    // read is requested by holding rd high until ready drops.
    localparam logic SD_READY_IDLE = 1'b1;
    localparam logic SD_RD_REQ     = 1'b1;

    // Width of a byte-lane index; a single-lane word still needs one bit.
    function automatic int lane_w(input int bpw);
        return (bpw > 1) ? $clog2(bpw) : 1;
    endfunction

endpackage

// File: rtl/sd_sector_loader_if.sv
// Bus bundle between the sector loader, sd_controller and the word memory.
// Latency: n/a (wires only).
// Backpressure: none on the memory side; sd side is paced by sd_ready/sd_rd.
// master: loader side (drives sd_rd/sd_address and mem_*).
// slave : controller/memory side (drives sd_ready/sd_dout/sd_byte_available).
interface sd_sector_loader_if
    import sd_pkg::*;
#(
    parameter int ADDR_W         = 16,
    parameter int BYTES_PER_WORD = 2
);
    logic                          sd_ready;
    logic                          sd_rd;
    logic [SD_ADDR_W-1:0]          sd_address;
    logic [7:0]                    sd_dout;
    logic                          sd_byte_available;
    logic                          mem_we;
    logic [ADDR_W-1:0]             mem_addr;
    logic [8*BYTES_PER_WORD-1:0]   mem_wdata;

    modport master (
        input  sd_ready, sd_dout, sd_byte_available,
        output sd_rd, sd_address, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        output sd_ready, sd_dout, sd_byte_available,
        input  sd_rd, sd_address, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/sd_sector_loader_byte_packer.sv
// Packs a stream of single bytes into little-endian words for memory writes.
// Latency: mem_we one clk after the byte that completes a word.
// Backpressure: none; every byte_vld is accepted, memory must take one word/clk.
// Ports: clk/reset; clear restarts lane and word address; byte_vld/byte_dat in;
// mem_we/mem_addr/mem_wdata out.
module sd_sector_loader_byte_packer
    import sd_pkg::*;
#(
    parameter int BYTES_PER_WORD = 2,
    parameter int ADDR_W         = 16
)(
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        clear,
    input  logic                        byte_vld,
    input  logic [7:0]                  byte_dat,
    output logic                        mem_we,
    output logic [ADDR_W-1:0]           mem_addr,
    output logic [8*BYTES_PER_WORD-1:0] mem_wdata
);
    localparam int                LANE_W    = lane_w(BYTES_PER_WORD);
    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(BYTES_PER_WORD - 1);

    logic [LANE_W-1:0]           lane;
    logic [8*BYTES_PER_WORD-1:0] acc;
    logic [8*BYTES_PER_WORD-1:0] acc_next;

    always_comb begin
        acc_next = acc;
        acc_next[8*int'(lane) +: 8] = byte_dat;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lane      <= '0;
            acc       <= '0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            mem_we <= 1'b0;
            // Address advances after the write cycle so the write uses the old value.
            if (mem_we)
                mem_addr <= mem_addr + ADDR_W'(1);
            if (clear) begin
                lane     <= '0;
                acc      <= '0;
                mem_addr <= '0;
            end else if (byte_vld) begin
                if (lane == LAST_LANE) begin
                    mem_wdata <= acc_next;
                    mem_we    <= 1'b1;
                    lane      <= '0;
                    acc       <= '0;
                end else begin
                    acc  <= acc_next;
                    lane <= lane + LANE_W'(1);
                end
            end
        end
    end
endmodule

// File: rtl/sd_sector_loader.sv
// Loads sector_count consecutive 512-byte SD sectors into word memory.
// Latency: done one clk after the final sector's trailing ready (or after start if count is 0).
// Backpressure: waits on sd_ready per sector; any wait over TIMEOUT_CYCLES aborts with error.
// Ports: clk, reset (async active-low), start/base_sector/sector_count request,
// busy/done/error status, bus (master) to sd_controller and word memory.
module sd_sector_loader
    import sd_pkg::*;
#(
    parameter int BYTES_PER_WORD = 2,
    parameter int ADDR_W         = 16,
    parameter int TIMEOUT_CYCLES = 50_000_000
)(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] base_sector,
    input  logic [15:0] sector_count,
    output logic        busy,
    output logic        done,
    output logic        error,
    sd_sector_loader_if.master bus
);
    localparam int               TMO_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    state_t                 state;
    logic [SD_ADDR_W-1:0]   base_q;
    logic [15:0]            count_q;
    logic [15:0]            sector_idx;
    logic [15:0]            idx_next;
    logic [9:0]             byte_cnt;
    logic [TMO_W-1:0]       tmo_cnt;
    logic                   strobe_q;
    logic                   byte_vld;
    logic                   pack_clear;
    logic                   in_wait;
    logic                   tmo_expired;
    logic                   ready_idle;

    assign ready_idle  = (bus.sd_ready == SD_READY_IDLE);
    // One byte per rising edge of the strobe, only while a sector is streaming.
    assign byte_vld    = bus.sd_byte_available && !strobe_q && (state == S_RECV);
    assign pack_clear  = start && (state == S_IDLE);
    assign idx_next    = sector_idx + 16'd1;
    assign in_wait     = (state inside {S_WAIT_READY, S_ISSUE, S_RECV, S_WAIT_END});
    // A byte arriving on the last cycle restarts the window rather than expiring it.
    assign tmo_expired = in_wait && (tmo_cnt == TMO_LAST) && !byte_vld;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            strobe_q <= 1'b0;
        else
            strobe_q <= bus.sd_byte_available;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state          <= S_IDLE;
            busy           <= 1'b0;
            done           <= 1'b0;
            error          <= 1'b0;
            bus.sd_rd      <= 1'b0;
            bus.sd_address <= '0;
            base_q         <= '0;
            count_q        <= '0;
            sector_idx     <= '0;
            byte_cnt       <= '0;
            tmo_cnt        <= '0;
        end else begin
            done    <= 1'b0;
            tmo_cnt <= tmo_cnt + TMO_W'(1);
            if (tmo_expired) begin
                error     <= 1'b1;
                bus.sd_rd <= ~SD_RD_REQ;
                busy      <= 1'b0;
                done      <= 1'b1;
                tmo_cnt   <= '0;
                state     <= S_DONE;
            end else begin
                case (state)
                    S_IDLE: begin
                        tmo_cnt <= '0;
                        if (start) begin
                            base_q         <= base_sector;
                            count_q        <= sector_count;
                            sector_idx     <= '0;
                            error          <= 1'b0;
                            bus.sd_address <= base_sector;
                            // done/busy are registered, so they change on entry to S_DONE.
                            if (sector_count == 16'd0) begin
                                done  <= 1'b1;
                                state <= S_DONE;
                            end else begin
                                busy  <= 1'b1;
                                state <= S_WAIT_READY;
                            end
                        end
                    end
                    S_WAIT_READY: begin
                        bus.sd_address <= base_q + {16'd0, sector_idx};
                        if (ready_idle) begin
                            bus.sd_rd <= SD_RD_REQ;
                            tmo_cnt   <= '0;
                            state     <= S_ISSUE;
                        end
                    end
                    S_ISSUE: begin
                        if (!ready_idle) begin
                            bus.sd_rd <= ~SD_RD_REQ;
                            byte_cnt  <= '0;
                            tmo_cnt   <= '0;
                            state     <= S_RECV;
                        end
                    end
                    S_RECV: begin
                        if (byte_vld) begin
                            tmo_cnt  <= '0;
                            byte_cnt <= byte_cnt + 10'd1;
                            if (byte_cnt == 10'(SECTOR_BYTES - 1))
                                state <= S_WAIT_END;
                        end else if (ready_idle) begin
                            // Controller went idle before a full sector: short read.
                            error   <= 1'b1;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                            tmo_cnt <= '0;
                            state   <= S_DONE;
                        end
                    end
                    S_WAIT_END: begin
                        // Trailing CRC strobes are ignored here; only ready matters.
                        if (ready_idle) begin
                            sector_idx <= idx_next;
                            tmo_cnt    <= '0;
                            if (idx_next == count_q) begin
                                busy  <= 1'b0;
                                done  <= 1'b1;
                                state <= S_DONE;
                            end else begin
                                bus.sd_address <= base_q + {16'd0, idx_next};
                                bus.sd_rd      <= SD_RD_REQ;
                                state          <= S_ISSUE;
                            end
                        end
                    end
                    S_DONE: begin
                        tmo_cnt <= '0;
                        state   <= S_IDLE;
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

    sd_sector_loader_byte_packer #(
        .BYTES_PER_WORD (BYTES_PER_WORD),
        .ADDR_W         (ADDR_W)
    ) u_packer (
        .clk       (clk),
        .reset     (reset),
        .clear     (pack_clear),
        .byte_vld  (byte_vld),
        .byte_dat  (bus.sd_dout),
        .mem_we    (bus.mem_we),
        .mem_addr  (bus.mem_addr),
        .mem_wdata (bus.mem_wdata)
    );
endmodule
